instruction_decode_stage: RTL

Registered, parametrised instruction decode stage for the basic CPU, successor to the combinational decoder. It accepts instruction words over a valid/ready handshake and assembles two-word LOAD instructions (opcode word plus immediate word). It emits one decoded bundle per instruction over a second valid/ready handshake, with TERM and illegal-opcode halt handling. It sits between instruction fetch and the register-file/ALU control FSM.

---
 rtl/instruction_decode_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instruction_decode_stage.sv
// Registered instruction decode stage. Words arrive and bundles leave over valid/ready handshakes.
// Two-word LOAD instructions are assembled here. TERM and illegal opcodes park the stage in HALT until resume.
module instruction_decode_stage #(
   parameter int OP_BITS  = 3,
   parameter int REG_BITS = 3,
   localparam int IW      = OP_BITS + 2*REG_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IW-1:0]       in_word,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OP_BITS-1:0]  out_op,
   output logic [REG_BITS-1:0] out_rx,
   output logic [REG_BITS-1:0] out_ry,
   output logic [IW-1:0]       out_imm,
   output logic                out_we,
   output logic                halted,
   output logic                illegal,
   input  logic                resume
);

   localparam logic [OP_BITS-1:0] OP_LOAD = OP_BITS'(0);
   localparam logic [OP_BITS-1:0] OP_MOVE = OP_BITS'(1);
   localparam logic [OP_BITS-1:0] OP_ADD  = OP_BITS'(2);
   localparam logic [OP_BITS-1:0] OP_XOR  = OP_BITS'(3);
   localparam logic [OP_BITS-1:0] OP_TERM = OP_BITS'(4);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      IMM   = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic                 out_valid_reg, out_valid_next;
   logic [OP_BITS-1:0]   out_op_reg, out_op_next;
   logic [REG_BITS-1:0]  out_rx_reg, out_rx_next;
   logic [REG_BITS-1:0]  out_ry_reg, out_ry_next;
   logic [IW-1:0]        out_imm_reg, out_imm_next;
   logic                 out_we_reg, out_we_next;
   logic                 illegal_reg, illegal_next;
   logic [REG_BITS-1:0]  rx_cap_reg, rx_cap_next;

   logic                 accept;
   logic                 emit;
   logic [OP_BITS-1:0]   word_op;
   logic [REG_BITS-1:0]  word_rx;
   logic [REG_BITS-1:0]  word_ry;

   assign word_op = in_word[IW-1 -: OP_BITS];
   assign word_rx = in_word[2*REG_BITS-1 -: REG_BITS];
   assign word_ry = in_word[REG_BITS-1:0];

   // The output register can take a new bundle when empty or when its current one leaves this cycle.
   assign in_ready = ((state_reg == FETCH) || (state_reg == IMM)) &&
                     (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= FETCH;
         out_valid_reg <= 1'b0;
         out_op_reg    <= '0;
         out_rx_reg    <= '0;
         out_ry_reg    <= '0;
         out_imm_reg   <= '0;
         out_we_reg    <= 1'b0;
         illegal_reg   <= 1'b0;
         rx_cap_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
         out_op_reg    <= out_op_next;
         out_rx_reg    <= out_rx_next;
         out_ry_reg    <= out_ry_next;
         out_imm_reg   <= out_imm_next;
         out_we_reg    <= out_we_next;
         illegal_reg   <= illegal_next;
         rx_cap_reg    <= rx_cap_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      illegal_next = illegal_reg;
      rx_cap_next  = rx_cap_reg;
      emit         = 1'b0;
      out_op_next  = out_op_reg;
      out_rx_next  = out_rx_reg;
      out_ry_next  = out_ry_reg;
      out_imm_next = out_imm_reg;
      out_we_next  = out_we_reg;

      case (state_reg)
         FETCH: begin
            if (accept) begin
               case (word_op)
                  OP_MOVE, OP_ADD, OP_XOR: begin
                     emit         = 1'b1;
                     out_op_next  = word_op;
                     out_rx_next  = word_rx;
                     out_ry_next  = word_ry;
                     out_imm_next = '0;
                     out_we_next  = 1'b1;
                  end
                  OP_LOAD: begin
                     rx_cap_next = word_rx;
                     state_next  = IMM;
                  end
                  OP_TERM: begin
                     emit         = 1'b1;
                     out_op_next  = OP_TERM;
                     out_rx_next  = '0;
                     out_ry_next  = '0;
                     out_imm_next = '0;
                     out_we_next  = 1'b0;
                     state_next   = HALT;
                  end
                  default: begin
                     illegal_next = 1'b1;
                     state_next   = HALT;
                  end
               endcase
            end
         end
         IMM: begin
            // The whole word is data here; its top bits are never looked at as an opcode.
            if (accept) begin
               emit         = 1'b1;
               out_op_next  = OP_LOAD;
               out_rx_next  = rx_cap_reg;
               out_ry_next  = '0;
               out_imm_next = in_word;
               out_we_next  = 1'b1;
               state_next   = FETCH;
            end
         end
         HALT: begin
            if (resume) begin
               illegal_next = 1'b0;
               state_next   = FETCH;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase

      if (emit)
         out_valid_next = 1'b1;
      else if (out_ready)
         out_valid_next = 1'b0;
      else
         out_valid_next = out_valid_reg;
   end

   assign out_valid = out_valid_reg;
   assign out_op    = out_op_reg;
   assign out_rx    = out_rx_reg;
   assign out_ry    = out_ry_reg;
   assign out_imm   = out_imm_reg;
   assign out_we    = out_we_reg;
   assign illegal   = illegal_reg;
   assign halted    = (state_reg == HALT);

endmodule
